trans_seq: RTL and testbench
============================

# trans_seq

Sequencer and collector that wraps the combinational row-to-column transpose unit of the matrix coprocessor. On `start`, it latches a 5x5 signed 8-bit matrix and streams one row per cycle to the transpose unit. It captures the column that unit returns on the same cycle and scatters its elements into the transposed result matrix. It pulses `done` when the full matrix is assembled, and it sits between the instruction decode/register stage and the result write-back.

## Interface
Parameters:
- `N`, default 5: matrix dimension (rows = columns).
- `W`, default 8: element width in bits, signed two's complement.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `start`  input  1: request a transpose; sampled only in IDLE.
- `matrix_in`  input  N*N*W (200): source matrix.
  - Row r, column c lives at bits `[N*N*W-1 - (r*N+c)*W -: W]`.
  - Row 0, column 0 is at `[199:192]`.
- `row_out`  output  N*W (40): row to the transpose unit; row element c at `[39-8c -: 8]`.
- `col_in`  input  N*W (40): column returned combinationally by the transpose unit for the current `row_out`.
- `busy`  output  1: high while rows are being streamed.
- `done`  output  1: one-cycle pulse, result valid.
- `matrix_out`  output  N*N*W (200): transposed matrix, same packing as `matrix_in`.

## Operation
- Internal state:
  - `src`: latched copy of `matrix_in`, 200 bits.
  - `idx`: row counter, 3 bits, range 0..4.
  - FSM: IDLE, FEED, DONE.
- IDLE:
  - `busy=0`, `done=0`, `row_out=0`.
  - On `start=1`, latch `matrix_in` into `src`, clear `matrix_out` to 0, set `idx=0`, go to FEED.
- FEED:
  - `busy=1`; `row_out` = row `idx` of `src` (registered-source mux, no extra delay).
  - Each edge, for c = 0..4, write `col_in[39-8c -: 8]` into `matrix_out` at row c, column `idx`.
  - If `idx==4`, go to DONE; otherwise increment `idx`.
- DONE:
  - `busy=0`, `done=1`, `row_out=0`; go to IDLE next edge.
- `matrix_out` holds its value after DONE until the next accepted `start`.
- `start` is ignored in FEED and DONE; no queuing.
- Elements are copied bit-exact. There is no arithmetic, sign extension or saturation.

## Timing
- Reset (`rst_n=0`, asynchronous) forces:
  - state IDLE, `idx=0`, `src=0`;
  - `matrix_out=0`, `row_out=0`, `busy=0`, `done=0`.
- Reset mid-operation aborts the transpose immediately. The partial result is discarded (`matrix_out=0`).
- Latency, with `start` sampled at edge 0:
  - rows 0..4 are presented in the cycles following edges 0..4 and captured at edges 1..5;
  - `done=1` in the cycle after edge 5;
  - IDLE again after edge 6.
- Total: 6 cycles from the `start` edge to `done` high, 7 cycles to ready.
- `busy` is high for exactly 5 cycles per operation.
- `matrix_in` may change after the `start` edge without affecting the result.
- `start` held high continuously gives back-to-back operations, one accepted every 7 cycles, each accepted on the IDLE edge.
- `col_in` must settle within the same cycle as `row_out`. The path is combinational through the transpose unit, which is held out of reset.

## Test plan
- Basic transpose: load element(r,c) = 10r+c and pulse `start` → after `done`:
  - element(r,c) = 10c+r, e.g. (0,1)=0x0A, (1,0)=0x01, (4,3)=0x22;
  - `busy` high for 5 cycles; `done` high for 1 cycle, in the 6th cycle after the start edge.
- Signed values:
  - (0,4)=0x80 (-128) → (4,0)=0x80;
  - (2,3)=0xFF → (3,2)=0xFF;
  - all diagonal elements unchanged; no other bits disturbed.
- Start while busy: pulse `start` again at edges 2 and 5 with a different `matrix_in` → ignored; the result equals the first matrix transposed; only one `done` pulse.
- Reset mid-op: deassert `rst_n` asynchronously between edges 3 and 4 → `matrix_out`, `row_out`, `busy` and `done` are 0 immediately. A new `start` after release produces the full correct transpose.
- Back-to-back: hold `start=1` with matrix A, then switch to matrix B after the first `done` → second `done` 7 cycles after the first, with `matrix_out` = Bᵀ. `matrix_out` was cleared to 0 on the second accept edge.
- Input isolation: change `matrix_in` every cycle during FEED → result equals the transpose of the value latched at the start edge.

Source files
------------

// File: rtl/trans_seq.sv
`default_nettype none
// ============================================================================
// Module   : trans_seq
// Brief    : Streams a latched NxN matrix row by row through an external
//            transpose unit and scatters the returned columns into the result.
// Revision : 1.0
// ============================================================================
module trans_seq #(
  parameter int N = 5,
  parameter int W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [N*N*W-1:0] matrix_in,
  output logic [N*W-1:0]   row_out,
  input  logic [N*W-1:0]   col_in,
  output logic             busy,
  output logic             done,
  output logic [N*N*W-1:0] matrix_out
);

  localparam int c_MW = N * N * W;
  localparam int c_RW = N * W;
  localparam int c_IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [c_IW-1:0]   r_idx;
  logic [c_MW-1:0]   r_src;
  logic [c_MW-1:0]   r_mat;
  logic [c_RW-1:0]   w_row;
  logic              w_busy;
  logic              w_done;

  // Row mux built from constant slices so every select stays in range.
  always_comb begin
    w_row = '0;
    for (int r = 0; r < N; r++) begin
      if (r_idx == c_IW'(r)) begin
        w_row = r_src[c_MW-1-r*c_RW -: c_RW];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_FEED;
        end
      end
      S_FEED: begin
        w_busy = 1'b1;
        if (r_idx == c_IW'(N - 1)) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_src   <= '0;
      r_mat   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src <= matrix_in;
            r_mat <= '0;
            r_idx <= '0;
          end
        end
        S_FEED: begin
          // Column element c of source row idx lands at result (c, idx).
          for (int r = 0; r < N; r++) begin
            if (r_idx == c_IW'(r)) begin
              for (int c = 0; c < N; c++) begin
                r_mat[c_MW-1-(c*N+r)*W -: W] <= col_in[c_RW-1-c*W -: W];
              end
            end
          end
          if (r_idx == c_IW'(N - 1)) begin
            r_idx <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign row_out    = w_busy ? w_row : '0;
  assign busy       = w_busy;
  assign done       = w_done;
  assign matrix_out = r_mat;

endmodule
`default_nettype wire

// File: tb/tb_trans_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_trans_seq
// Brief    : Directed bench for trans_seq with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_trans_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [199:0] matrix_in = '0;
  logic [39:0]  row_out;
  logic [39:0]  col_in;
  logic         busy;
  logic         done;
  logic [199:0] matrix_out;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  trans_seq #(.N(5), .W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .matrix_in(matrix_in),
    .row_out(row_out), .col_in(col_in), .busy(busy), .done(done),
    .matrix_out(matrix_out)
  );

  // The transpose unit hands back the row's elements as a column, in order.
  assign col_in = row_out;

  function automatic logic [7:0] el(input logic [199:0] m, input int r, input int c);
    return m[199-(r*5+c)*8 -: 8];
  endfunction

  function automatic logic [199:0] rnd200();
    logic [223:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return t[199:0];
  endfunction

  task automatic chk(input string name, input logic [199:0] act, input logic [199:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: operation phase k counts cycles since the accept edge.
  logic         m_act = 1'b0;
  int           m_k = 0;
  int           m_filled = 0;
  logic [199:0] m_src = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 1'b0; m_k = 0; m_filled = 0; m_src = '0;
    end else if (m_act) begin
      if (m_k < 5) m_filled++;
      m_k++;
      if (m_k == 6) m_act = 1'b0;
    end else if (start) begin
      m_act = 1'b1; m_k = 0; m_filled = 0; m_src = matrix_in;
    end
  end

  function automatic logic [199:0] exp_mat();
    logic [199:0] m;
    m = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        if (c < m_filled) m[199-(r*5+c)*8 -: 8] = el(m_src, c, r);
    return m;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      logic eb, ed;
      logic [39:0] er;
      eb = m_act && (m_k < 5);
      ed = m_act && (m_k == 5);
      er = eb ? m_src[199-m_k*40 -: 40] : 40'h0;
      chk("busy", 200'(busy), 200'(eb));
      chk("done", 200'(done), 200'(ed));
      chk("row_out", 200'(row_out), 200'(er));
      chk("matrix_out", matrix_out, exp_mat());
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // mode 0: plain; 1: extra start pulses with alt sampled at edges 2 and 5;
  // mode 2: matrix_in scrambled every cycle after the accept edge.
  task automatic run_op(input logic [199:0] m, input int mode, input logic [199:0] alt,
                        output int bc, output int dc, output int dat);
    bc = 0; dc = 0; dat = -1;
    matrix_in = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (busy) bc++;
      if (done) begin dc++; dat = i; end
      start = 1'b0;
      if (mode == 1 && (i == 1 || i == 4)) begin
        matrix_in = alt;
        start = 1'b1;
      end
      if (mode == 2) matrix_in = rnd200();
      tick();
    end
    start = 1'b0;
  endtask

  logic [199:0] ma, mb, ms;
  int bc, dc, dat, d1, d2;

  initial begin
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        ma[199-(r*5+c)*8 -: 8] = 8'(10*r + c);
    mb = rnd200();

    #1 rst_n = 1'b0;
    tick();
    chk("reset_busy", 200'(busy), 200'd0);
    chk("reset_matrix_out", matrix_out, 200'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Basic transpose
    run_op(ma, 0, '0, bc, dc, dat);
    chk("basic_busy_cycles", 200'(bc), 200'd5);
    chk("basic_done_count", 200'(dc), 200'd1);
    chk("basic_done_cycle", 200'(dat), 200'd5);
    chk("basic_el01", 200'(el(matrix_out, 0, 1)), 200'h0A);
    chk("basic_el10", 200'(el(matrix_out, 1, 0)), 200'h01);
    chk("basic_el43", 200'(el(matrix_out, 4, 3)), 200'h22);

    // Signed values
    ms = rnd200();
    ms[199-(0*5+4)*8 -: 8] = 8'h80;
    ms[199-(2*5+3)*8 -: 8] = 8'hFF;
    run_op(ms, 0, '0, bc, dc, dat);
    chk("signed_el40", 200'(el(matrix_out, 4, 0)), 200'h80);
    chk("signed_el32", 200'(el(matrix_out, 3, 2)), 200'hFF);
    for (int d = 0; d < 5; d++)
      chk("signed_diag", 200'(el(matrix_out, d, d)), 200'(el(ms, d, d)));

    // Start while busy is ignored
    run_op(ma, 1, mb, bc, dc, dat);
    chk("busy_start_done_count", 200'(dc), 200'd1);
    chk("busy_start_el01", 200'(el(matrix_out, 0, 1)), 200'h0A);
    chk("busy_start_el43", 200'(el(matrix_out, 4, 3)), 200'h22);
    tick(); tick();

    // Reset between edges 3 and 4
    matrix_in = mb;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midreset_matrix_out", matrix_out, 200'd0);
    chk("midreset_row_out", 200'(row_out), 200'd0);
    chk("midreset_busy", 200'(busy), 200'd0);
    chk("midreset_done", 200'(done), 200'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op(ma, 0, '0, bc, dc, dat);
    chk("postreset_done_count", 200'(dc), 200'd1);
    chk("postreset_el43", 200'(el(matrix_out, 4, 3)), 200'h22);

    // Back-to-back with start held
    matrix_in = ma;
    start = 1'b1;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done && d1 < 0) begin
        d1 = i;
        matrix_in = mb;
      end else if (done && d2 < 0) begin
        d2 = i;
        start = 1'b0;
      end
      if (d1 >= 0 && i == d1 + 2) begin
        chk("b2b_cleared", matrix_out, 200'd0);
        start = 1'b0;
      end
    end
    chk("b2b_spacing", 200'(d2 - d1), 200'd7);
    chk("b2b_el01", 200'(el(matrix_out, 0, 1)), 200'(el(mb, 1, 0)));
    tick();

    // Input isolation
    run_op(mb, 2, '0, bc, dc, dat);
    chk("isolate_el_24", 200'(el(matrix_out, 2, 4)), 200'(el(mb, 4, 2)));
    chk("isolate_el_31", 200'(el(matrix_out, 3, 1)), 200'(el(mb, 1, 3)));

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
